regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (PW/RW/E) between two writeback requesters: requester 0 = ALU/execute writeback, requester 1 = load/memory writeback.
- Each requester pushes into its own small FIFO.
- A round-robin arbiter pops one entry per cycle into a registered output stage that drives the register-file write port.
- Also exports a pending-write bitmap so issue logic can stall readers of registers with queued writes.

---
 rtl/regfile_write_arbiter_pkg.sv | 33 +++
 rtl/regfile_write_arbiter_if.sv | 46 ++++
 rtl/regfile_write_arbiter_wb_fifo.sv | 62 ++++++
 rtl/regfile_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Optional statistics counters are enabled with the REGFILE_ARB_STATS_EN macro.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // Identifies which writeback requester an entry came from.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    // One queued register-file write. addr occupies the MSBs of the packed form.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    localparam int ENTRY_W = $bits(wr_entry_t);

    // One-hot decode of a register address into the pending bitmap.
    function automatic logic [NUM_REGS-1:0] addr_decode(input logic [ADDR_W-1:0] addr);
        return NUM_REGS'(1) << addr;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request channels and register-file write port of the arbiter.
// With REGFILE_ARB_STATS_EN defined the bus also carries the statistics counters.
interface regfile_write_arbiter_if;
    import regfile_pkg::*;

    logic                LOCK;
    logic                W0_VALID;
    logic                W0_READY;
    logic [ADDR_W-1:0]   W0_ADDR;
    logic [DATA_W-1:0]   W0_DATA;
    logic                W1_VALID;
    logic                W1_READY;
    logic [ADDR_W-1:0]   W1_ADDR;
    logic [DATA_W-1:0]   W1_DATA;
    logic [DATA_W-1:0]   PW;
    logic [ADDR_W-1:0]   RW;
    logic                E;
    logic [NUM_REGS-1:0] PEND;
    logic                IDLE;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0]         GRANT0_CNT;
    logic [15:0]         GRANT1_CNT;
    logic [15:0]         STALL_CNT;

    modport master (
        output LOCK, W0_VALID, W0_ADDR, W0_DATA, W1_VALID, W1_ADDR, W1_DATA,
        input  W0_READY, W1_READY, PW, RW, E, PEND, IDLE,
        input  GRANT0_CNT, GRANT1_CNT, STALL_CNT
    );
    modport slave (
        input  LOCK, W0_VALID, W0_ADDR, W0_DATA, W1_VALID, W1_ADDR, W1_DATA,
        output W0_READY, W1_READY, PW, RW, E, PEND, IDLE,
        output GRANT0_CNT, GRANT1_CNT, STALL_CNT
    );
`else
    modport master (
        output LOCK, W0_VALID, W0_ADDR, W0_DATA, W1_VALID, W1_ADDR, W1_DATA,
        input  W0_READY, W1_READY, PW, RW, E, PEND, IDLE
    );
    modport slave (
        input  LOCK, W0_VALID, W0_ADDR, W0_DATA, W1_VALID, W1_ADDR, W1_DATA,
        output W0_READY, W1_READY, PW, RW, E, PEND, IDLE
    );
`endif

endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Small writeback FIFO. Pointers carry an extra wrap bit so full and empty
// are distinguishable. The key field (MSBs) of every slot is exposed with a
// valid bit so the owner can build the pending-write bitmap.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36,
    parameter int KEY_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [KEY_W-1:0] o_keys [DEPTH],
    output logic [DEPTH-1:0] o_valid
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   w_count;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Advance read/write pointers on accepted push and pop.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Store pushed entries into the slot addressed by the write pointer.
    // NOTE: storage is deliberately not reset; occupancy comes only from the pointers.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
    end

    // A slot is live when its distance from the read pointer is below the count.
    // NOTE: every output is given a default first so no latch can be inferred.
    always_comb begin
        o_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_keys[i]  = r_mem[i][WIDTH-1 -: KEY_W];
            o_valid[i] = (PTR_W+1)'(PTR_W'(PTR_W'(i) - r_rd_ptr[PTR_W-1:0])) < w_count;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// writeback (requester 0) and the memory writeback (requester 1). Each side
// queues into its own FIFO; one entry per cycle is moved into a registered
// PW/RW/E output stage. PEND flags every register with a write in flight.
// Optional macro REGFILE_ARB_STATS_EN adds grant and stall counters.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    regfile_write_arbiter_if.slave  bus
);

    logic               w_push0, w_push1;
    logic               w_pop0, w_pop1;
    logic               w_full0, w_full1;
    logic               w_empty0, w_empty1;
    logic [ENTRY_W-1:0] w_head0, w_head1;
    logic [ADDR_W-1:0]  w_keys0 [DEPTH];
    logic [ADDR_W-1:0]  w_keys1 [DEPTH];
    logic [DEPTH-1:0]   w_valid0, w_valid1;
    wr_entry_t          w_sel;
    wr_entry_t          w_in0, w_in1;
    logic [NUM_REGS-1:0] w_pend;

    req_id_e            r_last_grant;
    logic               r_e;
    logic [DATA_W-1:0]  r_pw;
    logic [ADDR_W-1:0]  r_rw;

    // READY depends on FIFO occupancy only, never on LOCK or a same-cycle pop.
    assign bus.W0_READY = !w_full0;
    assign bus.W1_READY = !w_full1;
    assign w_push0      = bus.W0_VALID && !w_full0;
    assign w_push1      = bus.W1_VALID && !w_full1;
    assign w_in0        = '{addr: bus.W0_ADDR, data: bus.W0_DATA};
    assign w_in1        = '{addr: bus.W1_ADDR, data: bus.W1_DATA};

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W), .KEY_W(ADDR_W)) u_fifo_alu (
        .i_clk       (CLK),
        .i_rst_n     (RESET),
        .i_push      (w_push0),
        .i_push_data (w_in0),
        .i_pop       (w_pop0),
        .o_head      (w_head0),
        .o_full      (w_full0),
        .o_empty     (w_empty0),
        .o_keys      (w_keys0),
        .o_valid     (w_valid0)
    );

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W), .KEY_W(ADDR_W)) u_fifo_mem (
        .i_clk       (CLK),
        .i_rst_n     (RESET),
        .i_push      (w_push1),
        .i_push_data (w_in1),
        .i_pop       (w_pop1),
        .o_head      (w_head1),
        .o_full      (w_full1),
        .o_empty     (w_empty1),
        .o_keys      (w_keys1),
        .o_valid     (w_valid1)
    );

    // Pick at most one FIFO to pop; on contention the one not granted last wins.
    always_comb begin
        w_pop0 = 1'b0;
        w_pop1 = 1'b0;
        if (!bus.LOCK) begin
            if (!w_empty0 && !w_empty1) begin
                if (r_last_grant == REQ_MEM) w_pop0 = 1'b1;
                else                         w_pop1 = 1'b1;
            end else if (!w_empty0) begin
                w_pop0 = 1'b1;
            end else if (!w_empty1) begin
                w_pop1 = 1'b1;
            end
        end
    end

    // Head of whichever FIFO is granted this cycle.
    always_comb begin
        w_sel = wr_entry_t'(w_head1);
        if (w_pop0) w_sel = wr_entry_t'(w_head0);
    end

    // Remember the most recent winner; reset value lets the ALU win first.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)      r_last_grant <= REQ_MEM;
        else if (w_pop0) r_last_grant <= REQ_ALU;
        else if (w_pop1) r_last_grant <= REQ_MEM;
    end

    // Registered write port: E pulses per pop, PW/RW hold between writes.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_e  <= 1'b0;
            r_pw <= '0;
            r_rw <= '0;
        end else begin
            r_e <= w_pop0 || w_pop1;
            if (w_pop0 || w_pop1) begin
                r_pw <= w_sel.data;
                r_rw <= w_sel.addr;
            end
        end
    end

    // Pending bitmap: every live FIFO slot plus the write currently on the port.
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid0[i]) w_pend = w_pend | addr_decode(w_keys0[i]);
            if (w_valid1[i]) w_pend = w_pend | addr_decode(w_keys1[i]);
        end
        if (r_e) w_pend = w_pend | addr_decode(r_rw);
    end

    assign bus.E    = r_e;
    assign bus.PW   = r_pw;
    assign bus.RW   = r_rw;
    assign bus.PEND = w_pend;
    assign bus.IDLE = w_empty0 && w_empty1 && !r_e;

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] r_grant0_cnt;
    logic [15:0] r_grant1_cnt;
    logic [15:0] r_stall_cnt;

    // Saturating counts of grants per requester and of locked cycles with work queued.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_grant0_cnt <= '0;
            r_grant1_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_pop0) r_grant0_cnt <= sat_inc16(r_grant0_cnt);
            if (w_pop1) r_grant1_cnt <= sat_inc16(r_grant1_cnt);
            if (bus.LOCK && !(w_empty0 && w_empty1)) r_stall_cnt <= sat_inc16(r_stall_cnt);
        end
    end

    assign bus.GRANT0_CNT = r_grant0_cnt;
    assign bus.GRANT1_CNT = r_grant1_cnt;
    assign bus.STALL_CNT  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based reference model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   started  = 0;

    regfile_write_arbiter_if bif();

    regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    wr_entry_t m_q0[$];
    wr_entry_t m_q1[$];
    bit              m_last = 1'b1;   // 1 = requester 1 granted last
    bit              m_e    = 1'b0;
    logic [ADDR_W-1:0] m_rw = '0;
    logic [DATA_W-1:0] m_pw = '0;
    bit              m_acc0 = 1'b0;
    bit              m_acc1 = 1'b0;
    int              m_g0 = 0, m_g1 = 0, m_stall = 0;

    always @(posedge clk or negedge rst_n) begin
        bit p0, p1;
        if (!rst_n) begin
            m_q0.delete();
            m_q1.delete();
            m_last = 1'b1;
            m_e = 1'b0; m_rw = '0; m_pw = '0;
            m_acc0 = 1'b0; m_acc1 = 1'b0;
            m_g0 = 0; m_g1 = 0; m_stall = 0;
        end else begin
            p0 = 1'b0; p1 = 1'b0;
            if (bif.LOCK == 1'b0) begin
                if (m_q0.size() > 0 && m_q1.size() > 0) begin
                    if (m_last) p0 = 1'b1; else p1 = 1'b1;
                end else if (m_q0.size() > 0) p0 = 1'b1;
                else if (m_q1.size() > 0) p1 = 1'b1;
            end else if (m_q0.size() > 0 || m_q1.size() > 0) begin
                if (m_stall < 65535) m_stall++;
            end
            m_acc0 = bif.W0_VALID && (m_q0.size() < DEPTH);
            m_acc1 = bif.W1_VALID && (m_q1.size() < DEPTH);
            if (p0) begin
                m_e = 1'b1; m_rw = m_q0[0].addr; m_pw = m_q0[0].data;
                void'(m_q0.pop_front()); m_last = 1'b0;
                if (m_g0 < 65535) m_g0++;
            end else if (p1) begin
                m_e = 1'b1; m_rw = m_q1[0].addr; m_pw = m_q1[0].data;
                void'(m_q1.pop_front()); m_last = 1'b1;
                if (m_g1 < 65535) m_g1++;
            end else begin
                m_e = 1'b0;
            end
            if (m_acc0) m_q0.push_back('{addr: bif.W0_ADDR, data: bif.W0_DATA});
            if (m_acc1) m_q1.push_back('{addr: bif.W1_ADDR, data: bif.W1_DATA});
        end
    end

    function automatic logic [NUM_REGS-1:0] model_pend();
        logic [NUM_REGS-1:0] p;
        p = '0;
        foreach (m_q0[i]) p[m_q0[i].addr] = 1'b1;
        foreach (m_q1[i]) p[m_q1[i].addr] = 1'b1;
        if (m_e) p[m_rw] = 1'b1;
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (started) begin
            check("E",        64'(bif.E),        64'(m_e));
            check("RW",       64'(bif.RW),       64'(m_rw));
            check("PW",       64'(bif.PW),       64'(m_pw));
            check("PEND",     64'(bif.PEND),     64'(model_pend()));
            check("IDLE",     64'(bif.IDLE),     64'(m_q0.size() == 0 && m_q1.size() == 0 && !m_e));
            check("W0_READY", 64'(bif.W0_READY), 64'(m_q0.size() < DEPTH));
            check("W1_READY", 64'(bif.W1_READY), 64'(m_q1.size() < DEPTH));
`ifdef REGFILE_ARB_STATS_EN
            check("GRANT0_CNT", 64'(bif.GRANT0_CNT), 64'(m_g0));
            check("GRANT1_CNT", 64'(bif.GRANT1_CNT), 64'(m_g1));
            check("STALL_CNT",  64'(bif.STALL_CNT),  64'(m_stall));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
        if (m_acc0) bif.W0_VALID = 1'b0;
        if (m_acc1) bif.W1_VALID = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bif.LOCK = 1'b0;
        bif.W0_VALID = 1'b0;
        bif.W1_VALID = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic req0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bif.W0_VALID = 1'b1; bif.W0_ADDR = a; bif.W0_DATA = d;
    endtask

    task automatic req1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bif.W1_VALID = 1'b1; bif.W1_ADDR = a; bif.W1_DATA = d;
    endtask

    initial begin
        rst_n = 1'b0;
        bif.LOCK = 1'b0;
        bif.W0_VALID = 1'b0; bif.W0_ADDR = '0; bif.W0_DATA = '0;
        bif.W1_VALID = 1'b0; bif.W1_ADDR = '0; bif.W1_DATA = '0;

        // Reset state
        do_reset();
        started = 1'b1;
        #1;
        check("rst_E",    64'(bif.E), 64'd0);
        check("rst_PW",   64'(bif.PW), 64'd0);
        check("rst_RW",   64'(bif.RW), 64'd0);
        check("rst_PEND", 64'(bif.PEND), 64'd0);
        check("rst_IDLE", 64'(bif.IDLE), 64'd1);
        check("rst_RDY0", 64'(bif.W0_READY), 64'd1);
        check("rst_RDY1", 64'(bif.W1_READY), 64'd1);

        // Single write
        step();
        req0(4'd3, 32'hDEADBEEF);
        step();
        check("single_queued_E", 64'(bif.E), 64'd0);
        check("single_queued_P", 64'(bif.PEND), 64'h0008);
        step();
        check("single_E",  64'(bif.E), 64'd1);
        check("single_RW", 64'(bif.RW), 64'd3);
        check("single_PW", 64'(bif.PW), 64'hDEADBEEF);
        check("single_P",  64'(bif.PEND), 64'h0008);
        step();
        check("single_E_drop", 64'(bif.E), 64'd0);
        check("single_P_drop", 64'(bif.PEND), 64'd0);
        check("single_IDLE",   64'(bif.IDLE), 64'd1);

        // Round-robin
        do_reset();
        bif.LOCK = 1'b1;
        req0(4'd1, 32'h1111_0001); req1(4'd5, 32'h5555_0005);
        step();
        req0(4'd2, 32'h2222_0002); req1(4'd6, 32'h6666_0006);
        step();
        check("rr_pend", 64'(bif.PEND), 64'h0066);
        bif.LOCK = 1'b0;
        step(); check("rr_1", 64'({bif.E, bif.RW}), 64'h11);
        step(); check("rr_2", 64'({bif.E, bif.RW}), 64'h15);
        step(); check("rr_3", 64'({bif.E, bif.RW}), 64'h12);
        check("rr_3_pw", 64'(bif.PW), 64'h2222_0002);
        step(); check("rr_4", 64'({bif.E, bif.RW}), 64'h16);
        step();
        check("rr_E_end", 64'(bif.E), 64'd0);
        check("rr_idle",  64'(bif.IDLE), 64'd1);

        // Full / backpressure
        do_reset();
        bif.LOCK = 1'b1;
        req1(4'd7, 32'h7);
        step(); check("full_rdy_1", 64'(bif.W1_READY), 64'd1);
        req1(4'd8, 32'h8);
        step(); check("full_rdy_2", 64'(bif.W1_READY), 64'd0);
        req1(4'd9, 32'h9);
        step();
        check("full_rdy_held", 64'(bif.W1_READY), 64'd0);
        check("full_pend_held", 64'(bif.PEND), 64'h0180);
        bif.LOCK = 1'b0;
        step();
        check("full_pop1", 64'({bif.E, bif.RW}), 64'h17);
        check("full_pend_pop1", 64'(bif.PEND), 64'h0180);
        step();
        check("full_pop2", 64'({bif.E, bif.RW}), 64'h18);
        check("full_pend_pop2", 64'(bif.PEND), 64'h0300);
        step();
        check("full_pop3", 64'({bif.E, bif.RW}), 64'h19);
        step();
        check("full_idle", 64'(bif.IDLE), 64'd1);

        // Reset mid-operation
        do_reset();
        bif.LOCK = 1'b1;
        req0(4'd4, 32'hA); req1(4'd10, 32'hB);
        step();
        req0(4'd11, 32'hC); req1(4'd12, 32'hD);
        step();
        bif.LOCK = 1'b0;
        step();
        check("mid_E_before", 64'(bif.E), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_E_async", 64'(bif.E), 64'd0);
        check("mid_PEND",    64'(bif.PEND), 64'd0);
        check("mid_IDLE",    64'(bif.IDLE), 64'd1);
        check("mid_RDY",     64'({bif.W0_READY, bif.W1_READY}), 64'h3);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_write", 64'(bif.E), 64'd0);
        end

`ifdef REGFILE_ARB_STATS_EN
        // Stats: 3 ALU grants, 2 MEM grants, 4 locked cycles with work queued
        do_reset();
        bif.LOCK = 1'b1;
        req0(4'd1, 32'h1); req1(4'd2, 32'h2);
        step();
        req0(4'd3, 32'h3); req1(4'd4, 32'h4);
        step();
        step();
        step();
        step();
        bif.LOCK = 1'b0;
        req0(4'd5, 32'h5);
        for (int i = 0; i < 8; i++) step();
        check("stat_g0",    64'(bif.GRANT0_CNT), 64'd3);
        check("stat_g1",    64'(bif.GRANT1_CNT), 64'd2);
        check("stat_stall", 64'(bif.STALL_CNT), 64'd4);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (!bif.W0_VALID && $urandom_range(0, 99) < 60)
                req0(ADDR_W'($urandom), $urandom);
            if (!bif.W1_VALID && $urandom_range(0, 99) < 50)
                req1(ADDR_W'($urandom), $urandom);
            if ($urandom_range(0, 99) < 8) bif.LOCK = ~bif.LOCK;
            step();
        end
        bif.LOCK = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("final_idle", 64'(bif.IDLE), 64'(bif.W0_VALID == 1'b0 && bif.W1_VALID == 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
